// File: rtl/dot_matrix_scan_pkg.sv
// Shared types and constants for the 8x8 dot-matrix scanner.
// Optional PWM dimming is enabled by defining DOT_MATRIX_PWM_EN.
package dm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } dm_state_e;

   localparam int DM_ROWS  = 8;
   localparam int DM_COLS  = 8;
   localparam int DM_ROW_W = $clog2(DM_ROWS);

   localparam logic [DM_ROWS-1:0] DM_ROW_OFF = 8'hFF;
   localparam logic [DM_COLS-1:0] DM_COL_OFF = 8'h00;

   // Active-low one-hot row select.
   function automatic logic [DM_ROWS-1:0] dm_row_sel(input logic [DM_ROW_W-1:0] row);
      dm_row_sel = ~(DM_ROWS'(1) << row);
   endfunction

endpackage

// File: rtl/dot_matrix_scan_if.sv
// Picture-word input and LED-pin outputs of the dot-matrix scanner.
// The Bright input exists only when DOT_MATRIX_PWM_EN is defined.
interface dot_matrix_scan_if;
   import dm_pkg::*;

   logic [DM_ROWS*DM_COLS-1:0] Frame_In;
   logic                       Scan_En;
   logic [DM_ROWS-1:0]         Row_Out;
   logic [DM_COLS-1:0]         Col_Out;
   logic                       Frame_Done;

`ifdef DOT_MATRIX_PWM_EN
   logic [2:0]                 Bright;

   modport slave  (input  Frame_In, Scan_En, Bright, output Row_Out, Col_Out, Frame_Done);
   modport master (output Frame_In, Scan_En, Bright, input  Row_Out, Col_Out, Frame_Done);
`else
   modport slave  (input  Frame_In, Scan_En, output Row_Out, Col_Out, Frame_Done);
   modport master (output Frame_In, Scan_En, input  Row_Out, Col_Out, Frame_Done);
`endif

endinterface

// File: rtl/dot_matrix_scan_row_timer.sv
// Slot prescaler, blank/drive phase FSM and row counter for the scanner.
// Exposes next-state phase/row so the caller can register outputs in step with the state.
module dm_row_timer
   import dm_pkg::*;
#(
   parameter int CLK_DIV   = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic                Sys_Clk,
   input  logic                Sys_Rst,
   input  logic                run_i,
   output dm_state_e           phase_o,
   output logic [DM_ROW_W-1:0] row_o,
   output logic                load_o,
   output logic                frame_end_o
);

   localparam int               DIV_W     = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

   dm_state_e           state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [DM_ROW_W-1:0] row_q, row_d;
   logic                slot_end;

   assign slot_end    = (state_q != IDLE) && (div_q == DIV_LAST);
   assign frame_end_o = slot_end && run_i && (row_q == DM_ROW_W'(DM_ROWS - 1));
   // Frame buffer loads on start-up from IDLE and at every completed frame.
   assign load_o      = run_i && ((state_q == IDLE) || frame_end_o);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      row_d   = row_q;
      if (!run_i) begin
         state_d = IDLE;
         div_d   = '0;
         row_d   = '0;
      end else begin
         if ((state_q == IDLE) || slot_end) begin
            div_d = '0;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
         if (state_q == IDLE) begin
            row_d = '0;
         end else if (slot_end) begin
            row_d = row_q + DM_ROW_W'(1);
         end
         state_d = (div_d < BLANK_END) ? BLANK : DRIVE;
      end
   end

   always_ff @(posedge Sys_Clk or negedge Sys_Rst) begin
      if (!Sys_Rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         row_q   <= row_d;
      end
   end

   assign phase_o = state_d;
   assign row_o   = row_d;

endmodule

// File: rtl/dot_matrix_scan.sv
// 8x8 LED dot-matrix scanner: latches a frame per frame boundary and drives one row per slot.
// Define DOT_MATRIX_PWM_EN to add Bright-controlled PWM dimming of the column data.
module dot_matrix_scan
   import dm_pkg::*;
#(
   parameter int CLK_DIV   = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic             Sys_Clk,
   input  logic             Sys_Rst,
   dot_matrix_scan_if.slave dm_bus
);

   dm_state_e                  phase_nxt;
   logic [DM_ROW_W-1:0]        row_nxt;
   logic                       load;
   logic                       frame_end;

   logic [DM_ROWS*DM_COLS-1:0] frame_buf_q, frame_buf_d;
   logic [DM_ROWS-1:0]         row_out_q, row_out_d;
   logic [DM_COLS-1:0]         col_out_q, col_out_d;
   logic                       frame_done_q, frame_done_d;

   dm_row_timer #(
      .CLK_DIV   (CLK_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .Sys_Clk     (Sys_Clk),
      .Sys_Rst     (Sys_Rst),
      .run_i       (dm_bus.Scan_En),
      .phase_o     (phase_nxt),
      .row_o       (row_nxt),
      .load_o      (load),
      .frame_end_o (frame_end)
   );

`ifdef DOT_MATRIX_PWM_EN
   // pwm_q holds the count for the next DRIVE cycle, so entry into DRIVE uses 0.
   logic [2:0] pwm_q, pwm_d;

   always_comb begin
      pwm_d = '0;
      if (phase_nxt == DRIVE) begin
         pwm_d = pwm_q + 3'd1;
      end
   end

   always_ff @(posedge Sys_Clk or negedge Sys_Rst) begin
      if (!Sys_Rst) begin
         pwm_q <= '0;
      end else begin
         pwm_q <= pwm_d;
      end
   end
`endif

   always_comb begin
      frame_buf_d  = load ? dm_bus.Frame_In : frame_buf_q;
      row_out_d    = DM_ROW_OFF;
      col_out_d    = DM_COL_OFF;
      frame_done_d = frame_end;
      if (phase_nxt == DRIVE) begin
         row_out_d = dm_row_sel(row_nxt);
         col_out_d = frame_buf_d[row_nxt*DM_COLS +: DM_COLS];
`ifdef DOT_MATRIX_PWM_EN
         if (pwm_q > dm_bus.Bright) begin
            col_out_d = DM_COL_OFF;
         end
`endif
      end
   end

   always_ff @(posedge Sys_Clk or negedge Sys_Rst) begin
      if (!Sys_Rst) begin
         frame_buf_q  <= '0;
         row_out_q    <= DM_ROW_OFF;
         col_out_q    <= DM_COL_OFF;
         frame_done_q <= 1'b0;
      end else begin
         frame_buf_q  <= frame_buf_d;
         row_out_q    <= row_out_d;
         col_out_q    <= col_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign dm_bus.Row_Out    = row_out_q;
   assign dm_bus.Col_Out    = col_out_q;
   assign dm_bus.Frame_Done = frame_done_q;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Directed, table-driven bench for dot_matrix_scan with CLK_DIV = 4, BLANK_CYC = 1.
// With DOT_MATRIX_PWM_EN defined, a second instance (CLK_DIV = 9) checks the dimming.
module tb_dot_matrix_scan;
   import dm_pkg::*;

   logic Sys_Clk = 1'b0;
   logic Sys_Rst = 1'b1;
   always #5 Sys_Clk = ~Sys_Clk;

   dot_matrix_scan_if bus ();

   dot_matrix_scan #(
      .CLK_DIV   (4),
      .BLANK_CYC (1)
   ) dut (
      .Sys_Clk (Sys_Clk),
      .Sys_Rst (Sys_Rst),
      .dm_bus  (bus)
   );

`ifdef DOT_MATRIX_PWM_EN
   dot_matrix_scan_if pbus ();

   dot_matrix_scan #(
      .CLK_DIV   (9),
      .BLANK_CYC (1)
   ) dut_pwm (
      .Sys_Clk (Sys_Clk),
      .Sys_Rst (Sys_Rst),
      .dm_bus  (pbus)
   );
`endif

   typedef struct {
      logic        en;
      logic [63:0] frame;
      logic [7:0]  row;
      logic [7:0]  col;
      logic        done;
   } vec_t;

   localparam logic [63:0] F2 = 64'h0000_0018_1800_0000;
   localparam logic [63:0] F3 = 64'hFF81_8181_8181_81FF;
   localparam logic [63:0] F4 = 64'h8040_2010_0804_0201;

   vec_t       vecs[$];
   logic [7:0] sel_tbl [8];
   logic [7:0] c_f2 [8];
   logic [7:0] c_f3 [8];
   logic [7:0] c_f4 [8];
   int         n_vec = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [7:0] a_row, input logic [7:0] a_col,
                        input logic a_done, input logic [7:0] e_row, input logic [7:0] e_col,
                        input logic e_done);
      n_vec++;
      if (a_row !== e_row || a_col !== e_col || a_done !== e_done) begin
         n_err++;
         $display("FAIL %s: got row=%h col=%h done=%b, expected row=%h col=%h done=%b",
                  name, a_row, a_col, a_done, e_row, e_col, e_done);
      end else begin
         $display("ok   %s: row=%h col=%h done=%b", name, a_row, a_col, a_done);
      end
   endtask

   task automatic check_main(input string name, input logic [7:0] e_row, input logic [7:0] e_col,
                             input logic e_done);
      check(name, bus.Row_Out, bus.Col_Out, bus.Frame_Done, e_row, e_col, e_done);
   endtask

   task automatic step();
      @(posedge Sys_Clk);
      @(negedge Sys_Clk);
   endtask

   function automatic void push(input logic en, input logic [63:0] frame, input logic [7:0] row,
                                input logic [7:0] col, input logic done);
      vec_t v;
      v.en    = en;
      v.frame = frame;
      v.row   = row;
      v.col   = col;
      v.done  = done;
      vecs.push_back(v);
   endfunction

   // One slot: a blank cycle followed by three drive cycles.
   function automatic void push_slot(input logic en, input logic [63:0] frame, input int r,
                                     input logic [7:0] col, input logic done);
      push(en, frame, 8'hFF, 8'h00, done);
      for (int k = 0; k < 3; k++) begin
         push(en, frame, sel_tbl[r], col, 1'b0);
      end
   endfunction

   initial begin
      sel_tbl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      c_f2    = '{8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00};
      c_f3    = '{8'hFF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF};
      c_f4    = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

      // Frame 1: first latch of F2.
      for (int s = 0; s < 8; s++) push_slot(1'b1, F2, s, c_f2[s], 1'b0);
      // Frame 2: Frame_In switches to F3 during row 2 but F2 stays on screen.
      for (int s = 0; s < 8; s++) push_slot(1'b1, (s < 2) ? F2 : F3, s, c_f2[s], s == 0);
      // Frame 3: F3 shown; Scan_En drops in row 5 DRIVE.
      for (int s = 0; s < 5; s++) push_slot(1'b1, F3, s, c_f3[s], s == 0);
      push(1'b1, F3, 8'hFF, 8'h00, 1'b0);
      push(1'b1, F3, 8'hDF, 8'h81, 1'b0);
      for (int k = 0; k < 4; k++) push(1'b0, F4, 8'hFF, 8'h00, 1'b0);
      // Restart from row 0 with a fresh latch of F4, then one full frame.
      for (int s = 0; s < 8; s++) push_slot(1'b1, F4, s, c_f4[s], 1'b0);
      push(1'b1, F4, 8'hFF, 8'h00, 1'b1);

      bus.Scan_En  = 1'b1;
      bus.Frame_In = F2;
`ifdef DOT_MATRIX_PWM_EN
      bus.Bright    = 3'd7;
      pbus.Scan_En  = 1'b0;
      pbus.Frame_In = {64{1'b1}};
      pbus.Bright   = 3'd3;
`endif

      // Reset held with Scan_En = 1.
      #1 Sys_Rst = 1'b0;
      #1 check_main("reset_immediate", 8'hFF, 8'h00, 1'b0);
      @(negedge Sys_Clk);
      for (int k = 0; k < 3; k++) begin
         step();
         check_main($sformatf("reset_hold%0d", k), 8'hFF, 8'h00, 1'b0);
      end
      Sys_Rst = 1'b1;

      foreach (vecs[i]) begin
         bus.Scan_En  = vecs[i].en;
         bus.Frame_In = vecs[i].frame;
         step();
         check_main($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].done);
      end

      // Scan_En falls on the row-7 slot-end edge: no Frame_Done.
      for (int k = 0; k < 31; k++) step();
      check_main("row7_drive", 8'h7F, 8'h80, 1'b0);
      bus.Scan_En = 1'b0;
      step();
      check_main("fall_at_frame_end", 8'hFF, 8'h00, 1'b0);
      step();
      check_main("idle_after_fall", 8'hFF, 8'h00, 1'b0);

      // Asynchronous reset mid-DRIVE.
      bus.Scan_En = 1'b1;
      step();
      check_main("restart_blank", 8'hFF, 8'h00, 1'b0);
      step();
      check_main("restart_drive", 8'hFE, 8'h01, 1'b0);
      #2 Sys_Rst = 1'b0;
      #1 check_main("async_reset", 8'hFF, 8'h00, 1'b0);
      @(negedge Sys_Clk);
      check_main("reset_held", 8'hFF, 8'h00, 1'b0);
      Sys_Rst = 1'b1;
      step();
      check_main("post_reset_blank", 8'hFF, 8'h00, 1'b0);
      step();
      check_main("post_reset_row0", 8'hFE, 8'h01, 1'b0);

`ifdef DOT_MATRIX_PWM_EN
      pbus.Scan_En = 1'b1;
      step();
      check("pwm_blank0", pbus.Row_Out, pbus.Col_Out, pbus.Frame_Done, 8'hFF, 8'h00, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("pwm_b3_%0d", k), pbus.Row_Out, pbus.Col_Out, pbus.Frame_Done,
               8'hFE, (k < 4) ? 8'hFF : 8'h00, 1'b0);
      end
      pbus.Bright = 3'd7;
      step();
      check("pwm_blank1", pbus.Row_Out, pbus.Col_Out, pbus.Frame_Done, 8'hFF, 8'h00, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("pwm_b7_%0d", k), pbus.Row_Out, pbus.Col_Out, pbus.Frame_Done,
               8'hFD, 8'hFF, 1'b0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
